// File: rtl/valid_sched_pkg.sv
// valid_sched_pkg: shared constants, slot record and latency lookup for the
// multi-latency valid/tag scheduler.
package valid_sched_pkg;

  localparam int TAG_W   = 8;
  localparam int NCLASS  = 4;
  localparam int MAX_LAT = 16;
  localparam int CLS_W   = (NCLASS > 1) ? $clog2(NCLASS) : 1;
  localparam int CNT_W   = 16;

  // Per-class latency in cycles; every entry must lie in 1..MAX_LAT.
  localparam int LATS [NCLASS] = '{1, 3, 5, 12};

  typedef struct packed {
    logic             v;
    logic [CLS_W-1:0] cls;
    logic [TAG_W-1:0] tag;
  } slot_t;

  // Latency of a class; 0 marks a class code outside 0..NCLASS-1.
  function automatic int lat_of(input logic [CLS_W-1:0] cls);
    int l;
    l = 0;
    for (int i = 0; i < NCLASS; i++) begin
      if (CLS_W'(i) == cls) l = LATS[i];
    end
    return l;
  endfunction

endpackage

// File: rtl/valid_sched_slot.sv
// valid_sched_slot: one completion slot. Each advancing cycle it either takes
// a freshly accepted issue or the contents of the slot above it; flush empties
// it. An empty slot always holds all-zero class and tag.
module valid_sched_slot
  import valid_sched_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ce_i,
  input  logic  flush_i,
  input  logic  load_i,
  input  slot_t load_data_i,
  input  slot_t shift_i,
  output slot_t slot_o
);

  slot_t slot_q, slot_d;

  // Next slot contents: flush wins, then load-on-accept, then shift down.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = '0;
    end else if (ce_i) begin
      if (load_i)          slot_d = load_data_i;
      else if (shift_i.v)  slot_d = shift_i;
      else                 slot_d = '0;
    end
  end

  // Slot register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/valid_sched.sv
// valid_sched: tracks valid+tag for several fixed-latency functional-unit
// classes sharing one writeback bus. An issue is accepted only when its
// completion slot is free, so at most one result emerges per cycle.
// Optional rejected-issue counter: define VALID_SCHED_REJECT_CNT_EN.
//
// Handshake: an issue transfers on a rising edge where in_valid & in_ready.
// in_ready depends only on ce, flush, in_class and slot state (never on
// in_valid). out_valid is a registered strobe that holds while ce=0, so
// consumers qualify it with ce.
module valid_sched
  import valid_sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CLS_W-1:0] in_class,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [CLS_W-1:0] out_class,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] reject_cnt
);

  localparam int IDX_W = $clog2(MAX_LAT + 2);

  // slots[MAX_LAT+1] is a permanently empty slot feeding the top of the pipe.
  slot_t              slots [1:MAX_LAT+1];
  logic [MAX_LAT+1:0] occ;
  int                 lat;
  logic               cls_ok;
  logic [IDX_W-1:0]   chk_idx;
  logic               accept;
  slot_t              issue_data;

  assign slots[MAX_LAT+1] = '0;

  // Occupancy vector indexed by slot number; bits 0 and MAX_LAT+1 stay empty.
  always_comb begin
    occ = '0;
    for (int k = 1; k <= MAX_LAT; k++) occ[k] = slots[k].v;
  end

  // Ready: the slot that will shift into position L must be empty.
  always_comb begin
    lat      = lat_of(in_class);
    cls_ok   = (lat != 0);
    chk_idx  = IDX_W'(lat + 1);
    in_ready = ce & ~flush & cls_ok & ~occ[chk_idx];
  end

  assign accept     = in_valid & in_ready;
  assign issue_data = '{v: 1'b1, cls: in_class, tag: in_tag};

  for (genvar k = 1; k <= MAX_LAT; k++) begin : g_slot
    valid_sched_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .ce_i        (ce),
      .flush_i     (flush),
      .load_i      (accept && (lat == k)),
      .load_data_i (issue_data),
      .shift_i     (slots[k+1]),
      .slot_o      (slots[k])
    );
  end

  assign out_valid = slots[1].v;
  assign out_class = slots[1].cls;
  assign out_tag   = slots[1].tag;
  assign busy      = |occ[MAX_LAT:1];

`ifdef VALID_SCHED_REJECT_CNT_EN
  logic [CNT_W-1:0] rej_q, rej_d;

  // Count cycles where a live issue was turned away; saturate at all-ones.
  always_comb begin
    rej_d = rej_q;
    if (in_valid & ~in_ready & ce & ~flush & (rej_q != '1)) rej_d = rej_q + 1'b1;
  end

  // Counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) rej_q <= '0;
    else       rej_q <= rej_d;
  end

  assign reject_cnt = rej_q;
`else
  assign reject_cnt = '0;
`endif

endmodule
